// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions a raw, bouncing, asynchronous pushbutton for timer_switch.
//   A two-flop synchroniser feeds a debounce FSM. The block emits one btn
//   pulse per confirmed press, a debounced pressed level, a one-shot
//   long_press pulse and a saturating press counter.
//
//   FSM states
//     state        | meaning
//     IDLE         | button released and stable
//     PRESS_WAIT   | sync2 high, counting stable cycles before confirming
//     PRESSED      | press confirmed, hold timer running
//     RELEASE_WAIT | sync2 low, counting stable cycles before confirming release
//
// Ports
//   clock        in   single clock, all state updates on posedge
//   reset        in   synchronous, active-high
//   btn_raw      in   raw button input, asynchronous, may bounce
//   btn          out  one-cycle pulse per confirmed press
//   pressed      out  debounced level (PRESSED or RELEASE_WAIT)
//   long_press   out  one-cycle pulse, at most once per press
//   press_count  out  confirmed presses since reset, saturating
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_raw,
  output logic             btn,
  output logic             pressed,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2;
  logic [DW-1:0]    deb_cnt, deb_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic             btn_d, pressed_d, long_d;
  logic [CNT_W-1:0] count_d;
  logic             deb_last;

  assign deb_last = (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

  // State register: synchroniser, FSM state, timers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      btn         <= 1'b0;
      pressed     <= 1'b0;
      long_press  <= 1'b0;
      press_count <= '0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      hold_cnt    <= hold_nxt;
      btn         <= btn_d;
      pressed     <= pressed_d;
      long_press  <= long_d;
      press_count <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = PRESS_WAIT;
          deb_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_nxt = IDLE;
        end else if (deb_last) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_nxt = RELEASE_WAIT;
          deb_nxt   = '0;
        end else if (hold_cnt != HW'(HOLD_CYCLES)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // hold_cnt stays frozen so a short release glitch cannot re-arm long_press
        if (sync2) begin
          state_nxt = PRESSED;
        end else if (deb_last) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    btn_d     = (state == PRESS_WAIT) && (state_nxt == PRESSED);
    pressed_d = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    // Fires only on the step into HOLD_CYCLES; saturation keeps it one-shot.
    long_d    = (state == PRESSED) && sync2 && (hold_cnt == HW'(HOLD_CYCLES - 1));
    count_d   = press_count;
    if (btn_d && (press_count != {CNT_W{1'b1}}))
      count_d = press_count + 1'b1;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       btn, pressed, long_press;
  logic [7:0] press_count;
  logic       s_btn, s_pressed, s_long;
  logic [1:0] s_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  button_conditioner dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn         (btn),
    .pressed     (pressed),
    .long_press  (long_press),
    .press_count (press_count)
  );

  button_conditioner #(.CNT_W(2)) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn         (s_btn),
    .pressed     (s_pressed),
    .long_press  (s_long),
    .press_count (s_count)
  );

  // After tick, edge k has happened and outputs are settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    btn_raw = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({btn, pressed, long_press} !== 3'b000 || press_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset: btn/pressed/long=%b%b%b count=%0d, want 000 count=0",
               btn, pressed, long_press, press_count);
    end
  endtask

  task automatic test_clean_press();
    apply_reset();
    btn_raw = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      n_cmp++;
      if (btn !== (t == 7)) begin
        n_err++;
        $display("FAIL clean_btn t=%0d: got %b want %b", t, btn, (t == 7));
      end
      n_cmp++;
      if (pressed !== (t >= 7 && t <= 18)) begin
        n_err++;
        $display("FAIL clean_pressed t=%0d: got %b want %b", t, pressed, (t >= 7 && t <= 18));
      end
      n_cmp++;
      if (long_press !== 1'b0) begin
        n_err++;
        $display("FAIL clean_long t=%0d: got %b want 0", t, long_press);
      end
      if (t == 12) btn_raw = 1'b0;
    end
    n_cmp++;
    if (press_count !== 8'd1) begin
      n_err++;
      $display("FAIL clean_count: got %0d want 1", press_count);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b0011_1011; // bit t-1 is btn_raw for sample t: 1,1,0,1,1,1,0,0
    apply_reset();
    for (int t = 1; t <= 20; t++) begin
      btn_raw = (t <= 8) ? pat[t-1] : 1'b0;
      tick();
      n_cmp++;
      if (btn !== 1'b0 || pressed !== 1'b0) begin
        n_err++;
        $display("FAIL bounce t=%0d: btn=%b pressed=%b want 0 0", t, btn, pressed);
      end
    end
    n_cmp++;
    if (press_count !== 8'd0) begin
      n_err++;
      $display("FAIL bounce_count: got %0d want 0", press_count);
    end
  endtask

  task automatic test_long_hold();
    int pulses;
    pulses = 0;
    apply_reset();
    btn_raw = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (long_press) pulses++;
      n_cmp++;
      if (long_press !== (t == 23)) begin
        n_err++;
        $display("FAIL long_timing t=%0d: got %b want %b", t, long_press, (t == 23));
      end
    end
    btn_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (long_press) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL long_count: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_release_glitch();
    apply_reset();
    btn_raw = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    btn_raw = 1'b0;
    for (int t = 11; t <= 30; t++) begin
      tick();
      if (t == 12) btn_raw = 1'b1;
      n_cmp++;
      if (pressed !== 1'b1 || btn !== 1'b0) begin
        n_err++;
        $display("FAIL glitch t=%0d: pressed=%b btn=%b want 1 0", t, pressed, btn);
      end
      // hold_cnt froze at 5 during the glitch, so it reaches 16 at edge 26
      n_cmp++;
      if (long_press !== (t == 26)) begin
        n_err++;
        $display("FAIL glitch_long t=%0d: got %b want %b", t, long_press, (t == 26));
      end
    end
    n_cmp++;
    if (press_count !== 8'd1) begin
      n_err++;
      $display("FAIL glitch_count: got %0d want 1", press_count);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      btn_raw = 1'b1;
      for (int t = 1; t <= 10; t++) tick();
      n_cmp++;
      if (s_count !== exp_sat[p]) begin
        n_err++;
        $display("FAIL sat_count press %0d: got %0d want %0d", p + 1, s_count, exp_sat[p]);
      end
      n_cmp++;
      if (press_count !== 8'(p + 1)) begin
        n_err++;
        $display("FAIL wide_count press %0d: got %0d want %0d", p + 1, press_count, p + 1);
      end
      btn_raw = 1'b0;
      for (int t = 1; t <= 10; t++) tick();
    end
  endtask

  task automatic test_reset_mid_press();
    apply_reset();
    btn_raw = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    n_cmp++;
    if (pressed !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: pressed=%b want 1", pressed);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({btn, pressed, long_press} !== 3'b000 || press_count !== 8'd0) begin
      n_err++;
      $display("FAIL midrst_clear: btn/pressed/long=%b%b%b count=%0d want 000 0",
               btn, pressed, long_press, press_count);
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_cmp++;
      if (btn !== (t == 7)) begin
        n_err++;
        $display("FAIL midrst_btn t=%0d: got %b want %b", t, btn, (t == 7));
      end
    end
    n_cmp++;
    if (press_count !== 8'd1) begin
      n_err++;
      $display("FAIL midrst_count: got %0d want 1", press_count);
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_saturation();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
